// File: rtl/sram_window_reader_if.sv
// Consumer-side stream of sram_window_reader: window request/rewind in, byte strobes out.
interface sram_window_reader_if;
  logic       request_in;
  logic       rewind;
  logic [7:0] data;
  logic [7:0] count;
  logic       write_out;
  logic       busy;
  logic       done;

  modport master (
    input  request_in, rewind,
    output data, count, write_out, busy, done
  );

  modport slave (
    output request_in, rewind,
    input  data, count, write_out, busy, done
  );
endinterface

// File: rtl/sram_window_reader.sv
// Streams WIN_BYTES-byte windows out of an asynchronous 16-bit SRAM, one word per
// SETUP/WAIT/LATCH access, low byte first, continuing through the frame between windows.
//   state   | meaning
//   IDLE    | wait for request_in; rewind clears the frame pointer
//   SETUP   | address driven, OE asserted
//   WAIT    | READ_WAIT cycles of access time
//   LATCH   | SRAM_DQ captured into the word buffer on exit
//   EMIT_LO | low byte strobed out
//   EMIT_HI | high byte strobed out; pointer advances on exit
//   DONE    | one-cycle completion pulse
module sram_window_reader #(
  parameter int WIN_BYTES   = 128,
  parameter int FRAME_WORDS = 19200,
  parameter int READ_WAIT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_window_reader_if.master bus,
  output logic [19:0]          SRAM_ADDR,
  inout  wire  [15:0]          SRAM_DQ,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_UB_N
);

  localparam logic [6:0]  LAST_WORD = 7'(WIN_BYTES / 2 - 1);
  localparam logic [19:0] LAST_PTR  = 20'(FRAME_WORDS - 1);
  localparam logic [2:0]  WAIT_LOAD = 3'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT, S_LATCH, S_EMIT_LO, S_EMIT_HI, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [19:0] r_ptr, w_ptr_nxt;
  logic [6:0]  r_word, w_word_nxt;
  logic [2:0]  r_wait, w_wait_nxt;
  logic [15:0] r_buf, w_buf_nxt;
  logic [19:0] r_addr;
  logic [7:0]  r_data, r_count;
  logic        r_write, r_busy, r_done, r_ce_n, r_oe_n;
  logic        w_access, w_reading;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_word_nxt  = r_word;
    w_wait_nxt  = r_wait;
    case (r_state)
      S_IDLE: begin
        // rewind is applied before the request so a simultaneous pair starts at word 0
        if (bus.rewind) w_ptr_nxt = '0;
        if (bus.request_in) begin
          w_state_nxt = S_SETUP;
          w_word_nxt  = '0;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_WAIT;
        w_wait_nxt  = WAIT_LOAD;
      end
      S_WAIT: begin
        if (r_wait == 3'd0) w_state_nxt = S_LATCH;
        else                w_wait_nxt  = r_wait - 3'd1;
      end
      S_LATCH:   w_state_nxt = S_EMIT_LO;
      S_EMIT_LO: w_state_nxt = S_EMIT_HI;
      S_EMIT_HI: begin
        w_ptr_nxt = (r_ptr == LAST_PTR) ? 20'd0 : r_ptr + 20'd1;
        if (r_word == LAST_WORD) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SETUP;
          w_word_nxt  = r_word + 7'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign w_buf_nxt = (r_state == S_LATCH) ? SRAM_DQ : r_buf;
  assign w_access  = (w_state_nxt == S_SETUP) || (w_state_nxt == S_WAIT) ||
                     (w_state_nxt == S_LATCH) || (w_state_nxt == S_EMIT_LO) ||
                     (w_state_nxt == S_EMIT_HI);
  assign w_reading = (w_state_nxt == S_SETUP) || (w_state_nxt == S_WAIT) ||
                     (w_state_nxt == S_LATCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_word  <= '0;
      r_wait  <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_write <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_word  <= w_word_nxt;
      r_wait  <= w_wait_nxt;
      r_buf   <= w_buf_nxt;
      if (w_state_nxt == S_SETUP) r_addr <= w_ptr_nxt;
      if (w_state_nxt == S_EMIT_LO) begin
        r_data  <= w_buf_nxt[7:0];
        r_count <= {r_word, 1'b0};
      end
      if (w_state_nxt == S_EMIT_HI) begin
        r_data  <= w_buf_nxt[15:8];
        r_count <= {r_word, 1'b1};
      end
      r_write <= (w_state_nxt == S_EMIT_LO) || (w_state_nxt == S_EMIT_HI);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_ce_n  <= ~w_access;
      r_oe_n  <= ~w_reading;
    end
  end

  assign bus.data      = r_data;
  assign bus.count     = r_count;
  assign bus.write_out = r_write;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  assign SRAM_ADDR = r_addr;
  assign SRAM_DQ   = 16'bz;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_LB_N = r_ce_n;
  assign SRAM_UB_N = r_ce_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_WE_N = 1'b1;

endmodule

// File: tb/tb_sram_window_reader.sv
// Scoreboard bench: two readers (FRAME_WORDS=100/READ_WAIT=1 and default frame/READ_WAIT=3)
// against an SRAM model and a frame-pointer reference model.
module tb_sram_window_reader;
  localparam int WIN   = 128;
  localparam int WORDS = WIN / 2;
  localparam int FW0   = 100;
  localparam int RW0   = 1;
  localparam int FW1   = 19200;
  localparam int RW1   = 3;

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  count;
    logic [19:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_window_reader_if if0 ();
  sram_window_reader_if if1 ();

  logic [1:0]  req, rew;
  wire  [15:0] dq0, dq1;
  logic [19:0] addr0, addr1;
  logic        ce0, oe0, we0, lb0, ub0;
  logic        ce1, oe1, we1, lb1, ub1;
  logic [15:0] mem1 [256];

  assign if0.request_in = req[0];
  assign if0.rewind     = rew[0];
  assign if1.request_in = req[1];
  assign if1.rewind     = rew[1];

  sram_window_reader #(.WIN_BYTES(WIN), .FRAME_WORDS(FW0), .READ_WAIT(RW0)) u0 (
    .clk(clk), .rst(rst), .bus(if0.master),
    .SRAM_ADDR(addr0), .SRAM_DQ(dq0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0),
    .SRAM_WE_N(we0), .SRAM_LB_N(lb0), .SRAM_UB_N(ub0)
  );

  sram_window_reader #(.WIN_BYTES(WIN), .FRAME_WORDS(FW1), .READ_WAIT(RW1)) u1 (
    .clk(clk), .rst(rst), .bus(if1.master),
    .SRAM_ADDR(addr1), .SRAM_DQ(dq1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1),
    .SRAM_WE_N(we1), .SRAM_LB_N(lb1), .SRAM_UB_N(ub1)
  );

  function automatic logic [15:0] exp_word(input int inst, input logic [19:0] a);
    if (inst == 0) return {a[7:0] + 8'h80, a[7:0]};
    return mem1[a[7:0]];
  endfunction

  assign dq0 = oe0 ? 16'hzzzz : exp_word(0, addr0);
  assign dq1 = oe1 ? 16'hzzzz : mem1[addr1[7:0]];

  wire [1:0] w_wo   = {if1.write_out, if0.write_out};
  wire [1:0] w_done = {if1.done, if0.done};
  wire [1:0] w_busy = {if1.busy, if0.busy};
  wire [1:0] w_oe   = {oe1, oe0};
  wire [1:0] w_ce   = {ce1, ce0};

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   mp[2]       = '{0, 0};
  int   done_cnt[2] = '{0, 0};
  int   oe_low[2]   = '{0, 0};
  int   ce_low[2]   = '{0, 0};
  int   last_lo[2]  = '{0, 0};
  int   ctl_bad     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_strobe(input int inst, input logic [7:0] d, input logic [7:0] c,
                              input logic [19:0] a);
    exp_t e;
    int   qs;
    qs = (inst == 0) ? q0.size() : q1.size();
    if (qs == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_strobe[%0d]: got count %0d, expected no strobe", inst, c);
      return;
    end
    e = (inst == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("data[%0d] #%0d", inst, e.count), {24'd0, d}, {24'd0, e.data});
    chk($sformatf("count[%0d]", inst), {24'd0, c}, {24'd0, e.count});
    chk($sformatf("addr[%0d] #%0d", inst, e.count), {12'd0, a}, {12'd0, e.addr});
    if (c[0] == 1'b0) begin
      if (c != 8'd0)
        chk($sformatf("word_span[%0d]", inst), cyc - last_lo[inst],
            ((inst == 0) ? RW0 : RW1) + 4);
      last_lo[inst] = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (if0.write_out) check_strobe(0, if0.data, if0.count, addr0);
    if (if1.write_out) check_strobe(1, if1.data, if1.count, addr1);
    for (int i = 0; i < 2; i++) begin
      if (w_done[i]) done_cnt[i]++;
      if (!w_oe[i])  oe_low[i]++;
      if (!w_ce[i])  ce_low[i]++;
    end
    if (lb0 !== ce0 || ub0 !== ce0 || we0 !== 1'b1 ||
        lb1 !== ce1 || ub1 !== ce1 || we1 !== 1'b1) ctl_bad++;
  end

  task automatic push_window(input int inst, input bit with_rew);
    exp_t        e;
    logic [15:0] wd;
    int          fw;
    fw = (inst == 0) ? FW0 : FW1;
    if (with_rew) mp[inst] = 0;
    for (int w = 0; w < WORDS; w++) begin
      e.addr  = 20'(mp[inst]);
      wd      = exp_word(inst, e.addr);
      e.data  = wd[7:0];
      e.count = 8'(2 * w);
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
      e.data  = wd[15:8];
      e.count = 8'(2 * w + 1);
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
      mp[inst] = (mp[inst] + 1) % fw;
    end
  endtask

  task automatic run_window(input int inst, input bit with_rew, input bit noise);
    int start, total, rw, d0, oe_s, ce_s;
    bit got_first, got_done;
    rw    = (inst == 0) ? RW0 : RW1;
    total = WORDS * (rw + 4);
    push_window(inst, with_rew);
    d0   = done_cnt[inst];
    oe_s = oe_low[inst];
    ce_s = ce_low[inst];
    @(negedge clk);
    req[inst] = 1'b1;
    rew[inst] = with_rew;
    start     = cyc + 1;
    got_first = 1'b0;
    got_done  = 1'b0;
    for (int t = 0; t < total + 20 && !got_done; t++) begin
      @(negedge clk);
      if (noise && (cyc - start) < total - 4) begin
        req[inst] = 1'($urandom_range(0, 1));
        rew[inst] = ($urandom_range(0, 7) == 0);
      end else begin
        req[inst] = 1'b0;
        rew[inst] = 1'b0;
      end
      if (t == 0) chk($sformatf("busy_after_start[%0d]", inst), w_busy[inst], 1);
      if (!got_first && w_wo[inst]) begin
        got_first = 1'b1;
        chk($sformatf("first_strobe_latency[%0d]", inst), cyc - start, rw + 2);
      end
      if (w_done[inst]) begin
        got_done = 1'b1;
        chk($sformatf("done_latency[%0d]", inst), cyc - start, total);
      end
    end
    req[inst] = 1'b0;
    rew[inst] = 1'b0;
    chk($sformatf("first_strobe_seen[%0d]", inst), got_first, 1);
    chk($sformatf("done_seen[%0d]", inst), got_done, 1);
    repeat (4) @(negedge clk);
    chk($sformatf("done_pulses[%0d]", inst), done_cnt[inst] - d0, 1);
    chk($sformatf("idle_after_done[%0d]", inst), w_busy[inst], 0);
    chk($sformatf("strobes_left[%0d]", inst), (inst == 0) ? q0.size() : q1.size(), 0);
    chk($sformatf("oe_low_cycles[%0d]", inst), oe_low[inst] - oe_s, WORDS * (rw + 2));
    chk($sformatf("ce_low_cycles[%0d]", inst), ce_low[inst] - ce_s, WORDS * (rw + 4));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;
    req = '0;
    rew = '0;
    for (int i = 0; i < 256; i++) mem1[i] = 16'($urandom);
    #1 rst = 1'b0;
    #2;
    chk("reset_strobe_busy_done", {if0.write_out, if0.busy, if0.done, if1.write_out, if1.busy, if1.done}, 0);
    chk("reset_data_count", {if0.data, if0.count, if1.data, if1.count}, 0);
    chk("reset_addr", {12'd0, addr0 | addr1}, 0);
    chk("reset_ctl", {ce0, oe0, we0, lb0, ub0, ce1, oe1, we1, lb1, ub1}, 10'h3ff);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_window(0, 1'b0, 1'b0);                       // words 0..63
    repeat ($urandom_range(0, 5)) @(negedge clk);
    run_window(0, 1'b0, 1'b1);                       // 64..99, 0..27 with ignored pulses
    repeat ($urandom_range(0, 5)) @(negedge clk);
    run_window(0, 1'b0, 1'b0);                       // 28..91
    run_window(0, 1'b0, 1'b1);                       // 92..99, 0..55
    run_window(0, 1'b1, 1'b0);                       // rewind + request together

    @(negedge clk);
    rew[0] = 1'b1;
    @(negedge clk);
    rew[0] = 1'b0;
    mp[0]  = 0;
    repeat (3) @(negedge clk);
    chk("rewind_only_stays_idle", {w_busy[0], w_wo[0]}, 0);
    run_window(0, 1'b0, 1'b0);

    run_window(1, 1'b0, 1'b0);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    run_window(1, 1'b0, 1'b1);

    push_window(0, 1'b0);
    @(negedge clk);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      @(negedge clk);
      if (w_wo[0] && if0.count == 8'd20) found = 1'b1;
    end
    chk("reached_word10_lo", found, 1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_strobe_busy", {w_wo[0], w_busy[0], w_done[0]}, 0);
    chk("midrst_ce_oe", {ce0, oe0}, 2'b11);
    chk("midrst_addr", {12'd0, addr0}, 0);
    q0.delete();
    q1.delete();
    mp[0] = 0;
    mp[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_after_reset_release", {w_busy[0], w_wo[0]}, 0);
    run_window(0, 1'b0, 1'b0);

    chk("lb_ub_we_track", ctl_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_window_reader.md
SRAM_WINDOW_READER -- requirements
Module: sram_window_reader

Interface
REQ-001 SHALL have parameter WIN_BYTES, default 128: bytes per window; even, 2..256.
REQ-002 SHALL have parameter FRAME_WORDS, default 19200: SRAM words per frame; the word pointer wraps here.
REQ-003 SHALL have parameter READ_WAIT, default 1: wait cycles between address setup and data capture; 1..7.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port request_in, input, 1: window request, sampled only in IDLE.
REQ-007 SHALL have port rewind, input, 1: reset the frame word pointer to 0, sampled only in IDLE.
REQ-008 SHALL have port data, output, 8: byte presented to the consumer.
REQ-009 SHALL have port count, output, 8: byte index of data within the window.
REQ-010 SHALL have port write_out, output, 1: one-cycle strobe marking data/count valid.
REQ-011 SHALL have port busy, output, 1: high while a window is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after the last byte of a window.
REQ-013 SHALL have port SRAM_ADDR, output, 20: SRAM word address.
REQ-014 SHALL have port SRAM_DQ, inout, 16: SRAM data bus; this block always drives it high-Z.
REQ-015 SHALL have ports SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N and SRAM_UB_N, each output, 1: active-low SRAM controls.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, WAIT, LATCH, EMIT_LO, EMIT_HI and DONE.
REQ-017 IDLE -> SETUP when request_in=1 at an edge; IDLE is held otherwise.
REQ-018 SETUP -> WAIT; WAIT SHALL last READ_WAIT cycles and then go to LATCH.
REQ-019 LATCH -> EMIT_LO, registering SRAM_DQ into the word buffer at the exit edge.
REQ-020 EMIT_LO -> EMIT_HI.
REQ-021 EMIT_HI -> SETUP if bytes remain in the window, else EMIT_HI -> DONE.
REQ-022 DONE -> IDLE unconditionally.
REQ-023 SRAM_ADDR SHALL equal the frame word pointer, registered on entry to SETUP, and SHALL be held stable through LATCH.
REQ-024 The frame word pointer SHALL increment on exit from EMIT_HI and wrap FRAME_WORDS-1 -> 0; a window may straddle the wrap.
REQ-025 Successive windows SHALL continue from the pointer value left by the previous window (streaming through the frame).
REQ-026 SRAM_CE_N, SRAM_LB_N and SRAM_UB_N SHALL be 0 in SETUP through EMIT_HI and 1 otherwise.
REQ-027 SRAM_OE_N SHALL be 0 in SETUP, WAIT and LATCH only; SRAM_WE_N SHALL be constant 1.
REQ-028 In EMIT_LO, outputs SHALL be data=buffer[7:0] and write_out=1; in EMIT_HI, data=buffer[15:8] and write_out=1; write_out SHALL be 0 in all other states.
REQ-029 count SHALL be 0 for the first byte of a window, increment by 1 per strobe, and never exceed WIN_BYTES-1.
REQ-030 All outputs SHALL be registered.
REQ-031 Each word SHALL take READ_WAIT+4 cycles; the first write_out SHALL be high in the cycle after the (READ_WAIT+2)-th edge following the edge that samples request_in.
REQ-032 busy SHALL be 1 from SETUP through DONE inclusive; done SHALL be 1 only in DONE.
REQ-033 request_in or rewind asserted while busy=1 SHALL be ignored, neither queued nor retriggering.
REQ-034 If rewind and request_in are both high in IDLE, the pointer SHALL clear first and the window SHALL start at word 0.
REQ-035 rewind alone in IDLE SHALL clear the pointer and leave the FSM in IDLE.

Reset
REQ-036 While rst=0, asynchronously: state=IDLE, pointer=0, SRAM_ADDR=0, word buffer=0, data=0, count=0, write_out=0, busy=0, done=0, all SRAM control outputs=1.
REQ-037 Reset asserted mid-window SHALL abort the window with no further write_out; after release the block SHALL wait in IDLE for a new request_in.

Verification
REQ-038 Bench SHALL cover a basic window: SRAM model word k = {k+0x80, k}, request_in pulse -> first strobe data=0x00 count=0, then data=0x80 count=1, ... 128 strobes with the last at count=127, done 320 cycles after start (READ_WAIT=1), SRAM_ADDR 0..63.
REQ-039 Bench SHALL cover streaming: a second request after done -> SRAM_ADDR starts at 64 and count restarts at 0.
REQ-040 Bench SHALL cover frame wrap: FRAME_WORDS=100, three windows -> third window addresses 28..91, a fourth window reads 92..99 then 0..55.
REQ-041 Bench SHALL cover rewind and simultaneity: rewind+request_in in the same IDLE cycle -> SRAM_ADDR=0 at first SETUP; request_in pulsed mid-window -> no extra window, done pulses once.
REQ-042 Bench SHALL cover mid-window reset: rst=0 during EMIT_LO of word 10 -> write_out=0, CE_N=OE_N=1, SRAM_ADDR=0 immediately; after release, the next window starts at address 0.
REQ-043 Bench SHALL cover READ_WAIT=3: each word spans 7 cycles; OE_N is low 5 cycles per word; data matches the model.
